// File: rtl/mipspipe_fetch.sv
// rtl/mipspipe_fetch.sv - MIPS pipeline instruction-fetch stage with IF/ID latch
// Holds the PC and word-addressed instruction memory, and stops fetching on a HALT word.
module mipspipe_fetch #(
   parameter int unsigned ADDR_W    = 6,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0020,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_wdata,
   output logic [31:0]       pc,
   output logic [31:0]       ifid_ir,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   state_t      state;
   logic [31:0] imem [DEPTH];
   logic [31:0] fetch_word;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;
   logic [15:0] count_next;

   // Upper PC bits are dropped here, so the fetch address wraps modulo the memory depth.
   assign fetch_word      = imem[pc[ADDR_W+1:2]];
   assign pc_plus4        = pc + 32'd4;
   assign redirect_target = {redirect_pc[31:2], 2'b00};
   assign count_next      = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
   assign halted          = (state == ST_HALTED);

   // Memory is not reset; the same-edge fetch above sees the old contents.
   always_ff @(posedge clock) begin
      if (prog_we) begin
         imem[prog_addr] <= prog_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         pc          <= RESET_PC;
         ifid_ir     <= NOP_WORD;
         ifid_pc4    <= 32'd0;
         ifid_valid  <= 1'b0;
         fetch_count <= 16'd0;
      end else if (redirect) begin
         state      <= ST_RUN;
         pc         <= redirect_target;
         ifid_ir    <= NOP_WORD;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!stall) begin
                  ifid_ir     <= fetch_word;
                  ifid_pc4    <= pc_plus4;
                  ifid_valid  <= 1'b1;
                  fetch_count <= count_next;
                  if (fetch_word == HALT_WORD) begin
                     state <= ST_HALTED;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            ST_HALTED: begin
               ifid_ir    <= NOP_WORD;
               ifid_valid <= 1'b0;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mipspipe_fetch.sv
// tb/tb_mipspipe_fetch.sv - randomized self-checking bench for mipspipe_fetch
// Directed program checks followed by random stall/redirect/program traffic against a reference model.
module tb_mipspipe_fetch;
   localparam int          AW   = 4;
   localparam logic [31:0] NOP  = 32'h0000_0020;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          redirect = 1'b0;
   logic [31:0]   redirect_pc = 32'd0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [31:0]   prog_wdata = 32'd0;
   logic [31:0]   pc, ifid_ir, ifid_pc4;
   logic          ifid_valid, halted;
   logic [15:0]   fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   mipspipe_fetch #(.ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .pc(pc), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4),
      .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   // Reference model: architectural state of the fetch stage, updated per edge.
   logic [31:0] m_mem [16];
   logic [31:0] m_pc, m_ir, m_pc4;
   logic        m_valid, m_halted;
   int          m_count;

   always @(posedge clock) begin
      if (prog_we) m_mem[prog_addr] <= prog_wdata;
   end

   always @(posedge clock or posedge reset) begin : model
      logic [31:0] w;
      if (reset) begin
         m_pc = 32'd0; m_ir = NOP; m_pc4 = 32'd0;
         m_valid = 1'b0; m_halted = 1'b0; m_count = 0;
      end else begin
         w = m_mem[(m_pc / 4) % 16];
         if (redirect) begin
            m_pc = redirect_pc & ~32'd3;
            m_ir = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
         end else if (m_halted) begin
            m_ir = NOP; m_valid = 1'b0;
         end else if (!stall) begin
            m_ir = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (m_count < 65535) m_count = m_count + 1;
            if (w == HALT) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("model_pc", pc, m_pc);
      chk("model_ir", ifid_ir, m_ir);
      chk("model_pc4", ifid_pc4, m_pc4);
      chk("model_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("model_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("model_count", {16'd0, fetch_count}, m_count[31:0]);
   end

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h8C01_0000; prog[1] = 32'h8C02_0004;
      prog[2] = 32'h0022_1820; prog[3] = HALT;
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_pc", pc, 32'd0);
      chk("rst_ir", ifid_ir, NOP);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_count", {16'd0, fetch_count}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1; prog_addr = i[AW-1:0];
         prog_wdata = (i < 4) ? prog[i] : NOP;
         step();
      end
      prog_we = 1'b0;
      reset = 1'b0;

      step();
      chk("e1_ir", ifid_ir, 32'h8C01_0000);
      chk("e1_pc4", ifid_pc4, 32'd4);
      step();
      chk("e2_ir", ifid_ir, 32'h8C02_0004);
      chk("e2_pc4", ifid_pc4, 32'd8);
      stall = 1'b1;
      step(); step();
      chk("stall_ir", ifid_ir, 32'h8C02_0004);
      chk("stall_pc", pc, 32'd8);
      chk("stall_count", {16'd0, fetch_count}, 32'd2);
      stall = 1'b0;
      step();
      chk("e3_ir", ifid_ir, 32'h0022_1820);
      step();
      chk("e4_ir", ifid_ir, HALT);
      chk("e4_halted", {31'd0, halted}, 32'd1);
      chk("e4_pc", pc, 32'h0000_000C);
      chk("e4_count", {16'd0, fetch_count}, 32'd4);
      step();
      chk("e5_ir", ifid_ir, NOP);
      chk("e5_valid", {31'd0, ifid_valid}, 32'd0);

      redirect = 1'b1; redirect_pc = 32'd0;
      step();
      chk("hexit_halted", {31'd0, halted}, 32'd0);
      redirect = 1'b0;
      step();
      chk("hexit_ir", ifid_ir, 32'h8C01_0000);

      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0006;
      step();
      chk("rs_pc", pc, 32'h0000_0004);
      chk("rs_ir", ifid_ir, NOP);
      chk("rs_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rs_count", {16'd0, fetch_count}, 32'd5);
      stall = 1'b0; redirect = 1'b0;
      step();
      chk("rs_next_ir", ifid_ir, 32'h8C02_0004);

      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      step();
      redirect = 1'b0;
      prog_we = 1'b1; prog_addr = '0; prog_wdata = 32'h1234_5678;
      step();
      chk("rbw_old_ir", ifid_ir, 32'h8C01_0000);
      chk("rbw_pc4", ifid_pc4, 32'h0000_0044);
      prog_we = 1'b0; redirect = 1'b1; redirect_pc = 32'd0;
      step();
      redirect = 1'b0;
      step();
      chk("rbw_new_ir", ifid_ir, 32'h1234_5678);

      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      redirect = 1'b0;
      step();
      chk("wrap_pc", pc, 32'd0);
      chk("wrap_pc4", ifid_pc4, 32'd0);

      #2 reset = 1'b1;
      #1;
      chk("pulse_pc", pc, 32'd0);
      chk("pulse_ir", ifid_ir, NOP);
      chk("pulse_count", {16'd0, fetch_count}, 32'd0);
      #1 reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 3000; i++) begin
         stall    = ($urandom_range(0, 4) == 0);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_00FF);
         prog_we  = ($urandom_range(0, 3) == 0);
         prog_addr = AW'($urandom_range(0, 15));
         prog_wdata = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
         step();
      end
      stall = 1'b0; redirect = 1'b0; prog_we = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
